// File: rtl/frequency_generation_stage_pkg.sv
// Shared widths, cell count, idle timeout and phase encoding for the Huffman
// frequency stage.
package frequency_generation_stage_pkg;

  localparam int DEF_SYMBOL_WIDTH = 5;
  localparam int DEF_FREQ_WIDTH   = 32;
  localparam int DEF_NUM_CELLS    = 16;
  localparam int DEF_IDLE_TIMEOUT = 8;

  typedef enum logic [1:0] {
    COLLECT,
    SORT,
    DONE
  } state_e;

endpackage

// File: rtl/frequency_generation_stage_freq_cell.sv
// One content-addressed {valid, symbol, freq} entry; the count saturates at all-ones.
// The sort load has priority over allocate, and allocate over increment.
module freq_cell #(
  parameter int SYMBOL_WIDTH = 5,
  parameter int FREQ_WIDTH   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [SYMBOL_WIDTH-1:0] sym_i,
  input  logic                    inc_i,
  input  logic                    alloc_i,
  input  logic                    load_i,
  input  logic                    load_vld_i,
  input  logic [SYMBOL_WIDTH-1:0] load_sym_i,
  input  logic [FREQ_WIDTH-1:0]   load_freq_i,
  output logic                    vld_o,
  output logic [SYMBOL_WIDTH-1:0] sym_o,
  output logic [FREQ_WIDTH-1:0]   freq_o,
  output logic                    match_o
);

  logic                    vld_q, vld_d;
  logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
  logic [FREQ_WIDTH-1:0]   freq_q, freq_d;

  always_comb begin
    vld_d  = vld_q;
    sym_d  = sym_q;
    freq_d = freq_q;
    if (load_i) begin
      vld_d  = load_vld_i;
      sym_d  = load_sym_i;
      freq_d = load_freq_i;
    end else if (alloc_i) begin
      vld_d  = 1'b1;
      sym_d  = sym_i;
      freq_d = FREQ_WIDTH'(1);
    end else if (inc_i && (freq_q != {FREQ_WIDTH{1'b1}})) begin
      freq_d = freq_q + FREQ_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      sym_q  <= '0;
      freq_q <= '0;
    end else begin
      vld_q  <= vld_d;
      sym_q  <= sym_d;
      freq_q <= freq_d;
    end
  end

  assign vld_o   = vld_q;
  assign sym_o   = sym_q;
  assign freq_o  = freq_q;
  assign match_o = vld_q && (sym_q == sym_i);

endmodule

// File: rtl/frequency_generation_stage.sv
// Counts symbol occurrences until the input idles, then odd-even transposition
// sorts the cells ascending by (valid first, freq, symbol) and holds the result.
module frequency_generation_stage
  import frequency_generation_stage_pkg::*;
#(
  parameter int SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
  parameter int FREQ_WIDTH   = DEF_FREQ_WIDTH,
  parameter int NUM_CELLS    = DEF_NUM_CELLS,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [SYMBOL_WIDTH-1:0]           symbol_in,
  input  logic                              valid_in,
  output logic                              ready_in,
  output logic [NUM_CELLS*FREQ_WIDTH-1:0]   sorted_frequencies,
  output logic [NUM_CELLS*SYMBOL_WIDTH-1:0] sorted_symbols,
  output logic                              sorted_done
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int PW = $clog2(NUM_CELLS + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic              seen_q, seen_d;

  logic                    cell_vld  [NUM_CELLS];
  logic [SYMBOL_WIDTH-1:0] cell_sym  [NUM_CELLS];
  logic [FREQ_WIDTH-1:0]   cell_freq [NUM_CELLS];
  logic                    nxt_vld   [NUM_CELLS];
  logic [SYMBOL_WIDTH-1:0] nxt_sym   [NUM_CELLS];
  logic [FREQ_WIDTH-1:0]   nxt_freq  [NUM_CELLS];
  logic [NUM_CELLS-1:0]    match;
  logic [NUM_CELLS-1:0]    alloc_sel;
  logic                    accept;
  logic                    sorting;
  logic                    found;

  assign ready_in    = (state_q == COLLECT);
  assign sorted_done = (state_q == DONE);
  assign accept      = valid_in && ready_in;
  assign sorting     = (state_q == SORT);

  // True when a must move behind b: empties sink, then freq, then symbol.
  function automatic logic out_of_order(
    input logic                    va,
    input logic [SYMBOL_WIDTH-1:0] sa,
    input logic [FREQ_WIDTH-1:0]   fa,
    input logic                    vb,
    input logic [SYMBOL_WIDTH-1:0] sb,
    input logic [FREQ_WIDTH-1:0]   fb
  );
    if (!va || !vb) return !va && vb;
    if (fa != fb)   return fa > fb;
    return sa > sb;
  endfunction

  always_comb begin
    alloc_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (!found && !cell_vld[i]) begin
        alloc_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_vld  = cell_vld;
    nxt_sym  = cell_sym;
    nxt_freq = cell_freq;
    for (int i = 0; i < NUM_CELLS - 1; i++) begin
      if ((i % 2) == int'(pass_q[0]) &&
          out_of_order(cell_vld[i], cell_sym[i], cell_freq[i],
                       cell_vld[i+1], cell_sym[i+1], cell_freq[i+1])) begin
        nxt_vld[i]    = cell_vld[i+1];
        nxt_sym[i]    = cell_sym[i+1];
        nxt_freq[i]   = cell_freq[i+1];
        nxt_vld[i+1]  = cell_vld[i];
        nxt_sym[i+1]  = cell_sym[i];
        nxt_freq[i+1] = cell_freq[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
    freq_cell #(
      .SYMBOL_WIDTH(SYMBOL_WIDTH),
      .FREQ_WIDTH  (FREQ_WIDTH)
    ) u_cell (
      .clk_i      (clk),
      .rst_i      (reset),
      .sym_i      (symbol_in),
      .inc_i      (accept && match[g]),
      .alloc_i    (accept && !(|match) && alloc_sel[g]),
      .load_i     (sorting),
      .load_vld_i (nxt_vld[g]),
      .load_sym_i (nxt_sym[g]),
      .load_freq_i(nxt_freq[g]),
      .vld_o      (cell_vld[g]),
      .sym_o      (cell_sym[g]),
      .freq_o     (cell_freq[g]),
      .match_o    (match[g])
    );
    assign sorted_symbols[g*SYMBOL_WIDTH +: SYMBOL_WIDTH] = cell_sym[g];
    assign sorted_frequencies[g*FREQ_WIDTH +: FREQ_WIDTH] = cell_freq[g];
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    pass_d  = pass_q;
    seen_d  = seen_q;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          idle_d = '0;
          seen_d = 1'b1;
        end else if (seen_q) begin
          // The idle count only runs once something has been seen.
          idle_d = idle_q + IW'(1);
          if (idle_d == IW'(IDLE_TIMEOUT)) begin
            state_d = SORT;
            pass_d  = '0;
          end
        end
      end
      SORT: begin
        pass_d = pass_q + PW'(1);
        if (pass_q == PW'(NUM_CELLS - 1)) state_d = DONE;
      end
      DONE: ;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      idle_q  <= '0;
      pass_q  <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      pass_q  <= pass_d;
      seen_q  <= seen_d;
    end
  end

endmodule

// File: tb/tb_frequency_generation_stage.sv
// Directed bench for frequency_generation_stage with hand-computed expectations.
module tb_frequency_generation_stage;

  localparam int SW = 5;
  localparam int FW = 32;
  localparam int NC = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [SW-1:0]    symbol_in = '0;
  logic             valid_in = 1'b0;
  logic             ready_in;
  logic [NC*FW-1:0] sorted_frequencies;
  logic [NC*SW-1:0] sorted_symbols;
  logic             sorted_done;

  int checks = 0;
  int errors = 0;

  frequency_generation_stage dut (
    .clk               (clk),
    .reset             (reset),
    .symbol_in         (symbol_in),
    .valid_in          (valid_in),
    .ready_in          (ready_in),
    .sorted_frequencies(sorted_frequencies),
    .sorted_symbols    (sorted_symbols),
    .sorted_done       (sorted_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cell(input string tag, input int i, input int s, input int f);
    chk($sformatf("%s_sym%0d", tag, i), 32'(sorted_symbols[i*SW +: SW]), 32'(s));
    chk($sformatf("%s_freq%0d", tag, i), sorted_frequencies[i*FW +: FW], 32'(f));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input int s);
    @(negedge clk);
    symbol_in = SW'(s);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!sorted_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(sorted_done), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_done", 32'(sorted_done), 32'd0);
    chk("rst_ready", 32'(ready_in), 32'd1);
    chk("rst_freq_any", 32'(|sorted_frequencies), 32'd0);
    chk("rst_sym_any", 32'(|sorted_symbols), 32'd0);

    // No input for 100 cycles: collection waits indefinitely
    repeat (100) @(negedge clk);
    chk("idle100_done", 32'(sorted_done), 32'd0);
    chk("idle100_ready", 32'(ready_in), 32'd1);

    // mississippi: m=0 i=1 s=2 p=3
    send(0); send(1); send(2); send(2); send(1); send(2);
    send(2); send(1); send(3); send(3); send(1);
    wait_done("miss", 200);
    chk("miss_ready", 32'(ready_in), 32'd0);
    chk_cell("miss", 0, 0, 1);
    chk_cell("miss", 1, 3, 2);
    chk_cell("miss", 2, 1, 4);
    chk_cell("miss", 3, 2, 4);
    for (int i = 4; i < NC; i++) chk_cell("miss", i, 0, 0);

    // valid_in pulses in DONE are ignored
    send(1); send(0); send(7);
    chk("done_pulse_ready", 32'(ready_in), 32'd0);
    chk_cell("done_pulse", 0, 0, 1);
    chk_cell("done_pulse", 2, 1, 4);
    chk_cell("done_pulse", 4, 0, 0);

    // Tie-break, allocation order, and exact phase timing
    do_reset();
    send(5); send(7); send(5); send(7); send(9);
    repeat (7) @(negedge clk);
    chk("tie_ready_before_timeout", 32'(ready_in), 32'd1);
    @(negedge clk);
    chk("tie_ready_after_timeout", 32'(ready_in), 32'd0);
    symbol_in = SW'(5);
    valid_in = 1'b1;
    repeat (15) @(negedge clk);
    chk("tie_done_early", 32'(sorted_done), 32'd0);
    valid_in = 1'b0;
    @(negedge clk);
    chk("tie_done_on_time", 32'(sorted_done), 32'd1);
    chk_cell("tie", 0, 9, 1);
    chk_cell("tie", 1, 5, 2);
    chk_cell("tie", 2, 7, 2);
    chk_cell("tie", 3, 0, 0);

    // Gap of IDLE_TIMEOUT-1 does not end collection
    do_reset();
    send(3);
    repeat (6) @(negedge clk);
    chk("gap_ready", 32'(ready_in), 32'd1);
    send(3);
    chk("gap_ready_after", 32'(ready_in), 32'd1);
    wait_done("gap", 100);
    chk_cell("gap", 0, 3, 2);
    chk_cell("gap", 1, 0, 0);

    // Overflow: 17 distinct symbols, the last one is dropped
    do_reset();
    for (int s = 0; s < 17; s++) send(s);
    wait_done("ovf", 200);
    for (int i = 0; i < NC; i++) chk_cell("ovf", i, i, 1);

    // Reset in the middle of SORT, then back-to-back accepts
    do_reset();
    send(1); send(2);
    begin
      int n = 0;
      while (ready_in && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("mid_sort_entered", 32'(ready_in), 32'd0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_done", 32'(sorted_done), 32'd0);
    chk("mid_rst_ready", 32'(ready_in), 32'd1);
    chk("mid_rst_freq_any", 32'(|sorted_frequencies), 32'd0);
    chk("mid_rst_sym_any", 32'(|sorted_symbols), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    symbol_in = SW'(4);
    valid_in = 1'b1;
    repeat (3) @(negedge clk);
    valid_in = 1'b0;
    chk_cell("b2b_live", 0, 4, 3);
    wait_done("b2b", 100);
    chk_cell("b2b", 0, 4, 3);
    chk_cell("b2b", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
